// File: rtl/spi_frame_reader_pkg.sv
// Shared frame layout, framing constants and FSM encoding for the SPI frame
// reader and any slave-side model that has to produce matching frames.
package spi_frame_reader_pkg;

    localparam int FRAME_LEN = 128;

    localparam logic [7:0] START_BYTE = 8'h7E;
    localparam logic [7:0] END_BYTE   = 8'h7D;
    localparam logic [7:0] ZERO_BYTE  = 8'h00;

    localparam int START_MSB = 127;
    localparam int START_LSB = 120;
    localparam int ID_MSB    = 119;
    localparam int ID_LSB    = 104;
    localparam int CYCLE_MSB = 103;
    localparam int CYCLE_LSB = 40;
    localparam int DATA_MSB  = 39;
    localparam int DATA_LSB  = 16;
    localparam int ZERO_MSB  = 15;
    localparam int ZERO_LSB  = 8;
    localparam int END_MSB   = 7;
    localparam int END_LSB   = 0;

    localparam int ID_WIDTH    = ID_MSB - ID_LSB + 1;
    localparam int CYCLE_WIDTH = CYCLE_MSB - CYCLE_LSB + 1;
    localparam int DATA_WIDTH  = DATA_MSB - DATA_LSB + 1;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_SETUP    = 3'd1;
    localparam logic [2:0] ST_SHIFT_LO = 3'd2;
    localparam logic [2:0] ST_SHIFT_HI = 3'd3;
    localparam logic [2:0] ST_HOLD     = 3'd4;
    localparam logic [2:0] ST_CHECK    = 3'd5;

    typedef struct packed {
        logic [ID_WIDTH-1:0]    id;
        logic [CYCLE_WIDTH-1:0] cycle;
        logic [DATA_WIDTH-1:0]  data;
    } trigger_fields_t;

    function automatic logic frame_ok(input logic [FRAME_LEN-1:0] frame);
        return (frame[START_MSB:START_LSB] == START_BYTE) &&
               (frame[ZERO_MSB:ZERO_LSB]   == ZERO_BYTE)  &&
               (frame[END_MSB:END_LSB]     == END_BYTE);
    endfunction

    function automatic trigger_fields_t extract_fields(input logic [FRAME_LEN-1:0] frame);
        trigger_fields_t f;
        f.id    = frame[ID_MSB:ID_LSB];
        f.cycle = frame[CYCLE_MSB:CYCLE_LSB];
        f.data  = frame[DATA_MSB:DATA_LSB];
        return f;
    endfunction

endpackage

// File: rtl/spi_frame_reader_if.sv
// Bus between the frame reader (SPI master side) and its environment, which
// supplies start and the slave's serial data and consumes the decoded fields.
interface spi_frame_reader_if;
    import spi_frame_reader_pkg::*;

    logic                   start;
    logic                   busy;
    logic                   spi_clk;
    logic                   spi_cs;
    logic                   spi_si;
    logic                   frame_valid;
    logic                   frame_error;
    logic [ID_WIDTH-1:0]    trigger_id;
    logic [CYCLE_WIDTH-1:0] trigger_cycle;
    logic [DATA_WIDTH-1:0]  trigger_data;
    logic [7:0]             err_count;

    modport master (
        input  start, spi_si,
        output busy, spi_clk, spi_cs, frame_valid, frame_error,
               trigger_id, trigger_cycle, trigger_data, err_count
    );

    modport slave (
        output start, spi_si,
        input  busy, spi_clk, spi_cs, frame_valid, frame_error,
               trigger_id, trigger_cycle, trigger_data, err_count
    );

endinterface

// File: rtl/spi_frame_reader_spi_clk_gen.sv
// Half-period timer for the SPI clock: strobes on the last cycle of every
// CLK_DIV-long half period while the reader is in an active phase.
module spi_clk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic sampling_clk,
    input  logic reset,
    input  logic active,
    input  logic clk_high,
    output logic rise,
    output logic fall
);

    localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

    logic [7:0] half_cnt_q;
    logic [7:0] half_cnt_d;
    logic       half_end;

    assign half_end = active && (half_cnt_q == LAST);

    // Low phases (SETUP and HOLD included) end with rise, high phases with fall.
    assign rise = half_end && !clk_high;
    assign fall = half_end &&  clk_high;

    always_comb begin
        half_cnt_d = half_cnt_q + 8'd1;
        if (!active || half_end) begin
            half_cnt_d = '0;
        end
    end

    always_ff @(posedge sampling_clk) begin
        if (reset) begin
            half_cnt_q <= '0;
        end else begin
            half_cnt_q <= half_cnt_d;
        end
    end

endmodule

// File: rtl/spi_frame_reader.sv
// SPI mode-0 master that reads one fixed 128-bit frame per start request,
// checks its framing bytes and publishes the trigger fields of good frames.
module spi_frame_reader
    import spi_frame_reader_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int FRAME_BITS = 128
) (
    input  logic                sampling_clk,
    input  logic                reset,
    spi_frame_reader_if.master  bus
);

    logic [2:0]             state_q, state_d;
    logic                   busy_q, busy_d;
    logic                   spi_clk_q, spi_clk_d;
    logic                   spi_cs_q, spi_cs_d;
    logic                   frame_valid_q, frame_valid_d;
    logic                   frame_error_q, frame_error_d;
    logic [FRAME_BITS-1:0]  shift_q, shift_d;
    logic [6:0]             bit_cnt_q, bit_cnt_d;
    logic [ID_WIDTH-1:0]    trigger_id_q, trigger_id_d;
    logic [CYCLE_WIDTH-1:0] trigger_cycle_q, trigger_cycle_d;
    logic [DATA_WIDTH-1:0]  trigger_data_q, trigger_data_d;
    logic [7:0]             err_count_q, err_count_d;

    logic            active;
    logic            clk_high;
    logic            rise;
    logic            fall;
    trigger_fields_t fields;

    assign active   = (state_q == ST_SETUP) || (state_q == ST_SHIFT_LO) ||
                      (state_q == ST_SHIFT_HI) || (state_q == ST_HOLD);
    assign clk_high = (state_q == ST_SHIFT_HI);
    assign fields   = extract_fields(shift_q);

    spi_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_spi_clk_gen (
        .sampling_clk (sampling_clk),
        .reset        (reset),
        .active       (active),
        .clk_high     (clk_high),
        .rise         (rise),
        .fall         (fall)
    );

    always_comb begin
        state_d         = state_q;
        shift_d         = shift_q;
        bit_cnt_d       = bit_cnt_q;
        frame_valid_d   = 1'b0;
        frame_error_d   = 1'b0;
        trigger_id_d    = trigger_id_q;
        trigger_cycle_d = trigger_cycle_q;
        trigger_data_d  = trigger_data_q;
        err_count_d     = err_count_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (rise) begin
                    state_d = ST_SHIFT_LO;
                end
            end
            ST_SHIFT_LO: begin
                if (rise) begin
                    state_d   = ST_SHIFT_HI;
                    shift_d   = {shift_q[FRAME_BITS-2:0], bus.spi_si};
                    bit_cnt_d = bit_cnt_q + 7'd1;
                end
            end
            ST_SHIFT_HI: begin
                // The counter has wrapped back to zero only after the 128th sample.
                if (fall) begin
                    state_d = (bit_cnt_q == 7'd0) ? ST_HOLD : ST_SHIFT_LO;
                end
            end
            ST_HOLD: begin
                if (rise) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                state_d = ST_IDLE;
                if (frame_ok(shift_q)) begin
                    frame_valid_d   = 1'b1;
                    trigger_id_d    = fields.id;
                    trigger_cycle_d = fields.cycle;
                    trigger_data_d  = fields.data;
                end else begin
                    frame_error_d = 1'b1;
                    if (err_count_q != 8'hFF) begin
                        err_count_d = err_count_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d    = (state_d != ST_IDLE);
        spi_clk_d = (state_d == ST_SHIFT_HI);
        spi_cs_d  = !((state_d == ST_SETUP) || (state_d == ST_SHIFT_LO) ||
                      (state_d == ST_SHIFT_HI) || (state_d == ST_HOLD));
    end

    always_ff @(posedge sampling_clk) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            busy_q          <= 1'b0;
            spi_clk_q       <= 1'b0;
            spi_cs_q        <= 1'b1;
            frame_valid_q   <= 1'b0;
            frame_error_q   <= 1'b0;
            shift_q         <= '0;
            bit_cnt_q       <= '0;
            trigger_id_q    <= '0;
            trigger_cycle_q <= '0;
            trigger_data_q  <= '0;
            err_count_q     <= '0;
        end else begin
            state_q         <= state_d;
            busy_q          <= busy_d;
            spi_clk_q       <= spi_clk_d;
            spi_cs_q        <= spi_cs_d;
            frame_valid_q   <= frame_valid_d;
            frame_error_q   <= frame_error_d;
            shift_q         <= shift_d;
            bit_cnt_q       <= bit_cnt_d;
            trigger_id_q    <= trigger_id_d;
            trigger_cycle_q <= trigger_cycle_d;
            trigger_data_q  <= trigger_data_d;
            err_count_q     <= err_count_d;
        end
    end

    assign bus.busy          = busy_q;
    assign bus.spi_clk       = spi_clk_q;
    assign bus.spi_cs        = spi_cs_q;
    assign bus.frame_valid   = frame_valid_q;
    assign bus.frame_error   = frame_error_q;
    assign bus.trigger_id    = trigger_id_q;
    assign bus.trigger_cycle = trigger_cycle_q;
    assign bus.trigger_data  = trigger_data_q;
    assign bus.err_count     = err_count_q;

endmodule

// File: tb/tb_spi_frame_reader.sv
// Directed bench for spi_frame_reader: one reader at CLK_DIV=4 and one at
// CLK_DIV=1, each fed by a mode-0 slave model serving a shared frame image.
module tb_spi_frame_reader;

    localparam logic [127:0] GOOD_A =
        {8'h7E, 16'h1234, 64'h0000_0000_DEAD_BEEF, 24'hABCDEF, 8'h00, 8'h7D};
    localparam logic [127:0] GOOD_B =
        {8'h7E, 16'hA55A, 64'h0123_4567_89AB_CDEF, 24'h13579B, 8'h00, 8'h7D};
    localparam logic [127:0] BAD_START =
        {8'h7F, 16'h1234, 64'h0000_0000_DEAD_BEEF, 24'hABCDEF, 8'h00, 8'h7D};

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    spi_frame_reader_if bus_a ();
    spi_frame_reader_if bus_b ();

    spi_frame_reader #(.CLK_DIV(4), .FRAME_BITS(128)) dut_a (
        .sampling_clk (clock),
        .reset        (reset),
        .bus          (bus_a)
    );

    spi_frame_reader #(.CLK_DIV(1), .FRAME_BITS(128)) dut_b (
        .sampling_clk (clock),
        .reset        (reset),
        .bus          (bus_b)
    );

    // Mode-0 slave: MSB ready when cs falls, next bit after each falling spi_clk.
    logic [127:0] slave_frame = '0;
    int idx_a = 0;
    int idx_b = 0;

    always @(negedge bus_a.spi_clk or posedge bus_a.spi_cs) begin
        if (bus_a.spi_cs) idx_a <= 0;
        else              idx_a <= idx_a + 1;
    end

    always @(negedge bus_b.spi_clk or posedge bus_b.spi_cs) begin
        if (bus_b.spi_cs) idx_b <= 0;
        else              idx_b <= idx_b + 1;
    end

    assign bus_a.spi_si = (idx_a < 128) ? slave_frame[7'(127 - idx_a)] : 1'b0;
    assign bus_b.spi_si = (idx_b < 128) ? slave_frame[7'(127 - idx_b)] : 1'b0;

    int clk_pulses_a = 0;
    int clk_pulses_b = 0;
    int res_pulses_a = 0;
    int both_cnt     = 0;

    always @(posedge bus_a.spi_clk) clk_pulses_a <= clk_pulses_a + 1;
    always @(posedge bus_b.spi_clk) clk_pulses_b <= clk_pulses_b + 1;

    always @(posedge clock) begin
        if (bus_a.frame_valid || bus_a.frame_error) res_pulses_a <= res_pulses_a + 1;
        if ((bus_a.frame_valid && bus_a.frame_error) ||
            (bus_b.frame_valid && bus_b.frame_error)) both_cnt <= both_cnt + 1;
    end

    int checks   = 0;
    int failures = 0;

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    function automatic logic result_pulse(input bit on_b);
        return on_b ? (bus_b.frame_valid | bus_b.frame_error)
                    : (bus_a.frame_valid | bus_a.frame_error);
    endfunction

    // Loads the slave image and pulses start on reader A; returns in cycle 1.
    task automatic applyStimulus(input logic [127:0] frame);
        slave_frame = frame;
        bus_a.start = 1'b1;
        @(posedge clock);
        #1;
        bus_a.start = 1'b0;
    endtask

    task automatic waitResult(input bit on_b, input int from_cyc, input int limit,
                              output int cyc);
        cyc = from_cyc;
        while (!result_pulse(on_b) && cyc < limit) begin
            @(posedge clock);
            #1;
            cyc++;
        end
        checkOutput("result pulse seen", result_pulse(on_b), 1'b1);
    endtask

    initial begin
        #1_500_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int          cyc;
        int          pulses0;
        int          res0;
        logic [11:0] clk_pat;
        logic [11:0] cs_pat;
        logic [5:0]  pat6;

        reset       = 1'b1;
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checkOutput("reset busy",          bus_a.busy,          1'b0);
        checkOutput("reset spi_clk",       bus_a.spi_clk,       1'b0);
        checkOutput("reset spi_cs",        bus_a.spi_cs,        1'b1);
        checkOutput("reset frame_valid",   bus_a.frame_valid,   1'b0);
        checkOutput("reset frame_error",   bus_a.frame_error,   1'b0);
        checkOutput("reset trigger_id",    bus_a.trigger_id,    16'h0);
        checkOutput("reset trigger_cycle", bus_a.trigger_cycle, 64'h0);
        checkOutput("reset trigger_data",  bus_a.trigger_data,  24'h0);
        checkOutput("reset err_count",     bus_a.err_count,     8'h0);
        reset = 1'b0;
        @(posedge clock);
        #1;

        $display("[TB] good frame at CLK_DIV=4");
        pulses0 = clk_pulses_a;
        applyStimulus(GOOD_A);
        checkOutput("busy after accept", bus_a.busy, 1'b1);
        clk_pat = '0;
        cs_pat  = '0;
        for (int i = 0; i < 12; i++) begin
            clk_pat = {clk_pat[10:0], bus_a.spi_clk};
            cs_pat  = {cs_pat[10:0], bus_a.spi_cs};
            if (i < 11) begin
                @(posedge clock);
                #1;
            end
        end
        checkOutput("setup and first pulse spi_clk", clk_pat, 12'h00F);
        checkOutput("setup and first pulse spi_cs",  cs_pat,  12'h000);
        waitResult(0, 12, 1100, cyc);
        checkOutput("good latency",       cyc,                  1034);
        checkOutput("good frame_valid",   bus_a.frame_valid,    1'b1);
        checkOutput("good frame_error",   bus_a.frame_error,    1'b0);
        checkOutput("good trigger_id",    bus_a.trigger_id,     16'h1234);
        checkOutput("good trigger_cycle", bus_a.trigger_cycle,  64'hDEAD_BEEF);
        checkOutput("good trigger_data",  bus_a.trigger_data,   24'hABCDEF);
        checkOutput("good spi_clk pulses", clk_pulses_a - pulses0, 128);
        checkOutput("busy low at result", bus_a.busy,   1'b0);
        checkOutput("cs high at result",  bus_a.spi_cs, 1'b1);
        @(posedge clock);
        #1;
        checkOutput("frame_valid one cycle", bus_a.frame_valid, 1'b0);

        $display("[TB] bad start byte");
        applyStimulus(BAD_START);
        waitResult(0, 1, 1100, cyc);
        checkOutput("bad latency",       cyc,                 1034);
        checkOutput("bad frame_error",   bus_a.frame_error,   1'b1);
        checkOutput("bad frame_valid",   bus_a.frame_valid,   1'b0);
        checkOutput("bad err_count",     bus_a.err_count,     8'd1);
        checkOutput("bad trigger_id",    bus_a.trigger_id,    16'h1234);
        checkOutput("bad trigger_cycle", bus_a.trigger_cycle, 64'hDEAD_BEEF);
        checkOutput("bad trigger_data",  bus_a.trigger_data,  24'hABCDEF);
        @(posedge clock);
        #1;
        checkOutput("frame_error one cycle", bus_a.frame_error, 1'b0);

        $display("[TB] start while busy");
        res0    = res_pulses_a;
        pulses0 = clk_pulses_a;
        applyStimulus(GOOD_B);
        repeat (499) @(posedge clock);
        #1;
        bus_a.start = 1'b1;
        @(posedge clock);
        #1;
        bus_a.start = 1'b0;
        checkOutput("busy during ignored start", bus_a.busy, 1'b1);
        waitResult(0, 501, 1100, cyc);
        checkOutput("ignored-start latency",   cyc,                 1034);
        checkOutput("ignored-start valid",     bus_a.frame_valid,   1'b1);
        checkOutput("ignored-start id",        bus_a.trigger_id,    16'hA55A);
        checkOutput("ignored-start cycle",     bus_a.trigger_cycle, 64'h0123_4567_89AB_CDEF);
        checkOutput("ignored-start data",      bus_a.trigger_data,  24'h13579B);
        checkOutput("ignored-start spi_clk pulses", clk_pulses_a - pulses0, 128);
        repeat (20) @(posedge clock);
        #1;
        checkOutput("ignored-start result pulses", res_pulses_a - res0, 1);
        checkOutput("ignored start not queued",    bus_a.busy,          1'b0);

        $display("[TB] reset mid-frame");
        res0 = res_pulses_a;
        applyStimulus(GOOD_A);
        repeat (299) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        checkOutput("abort spi_cs",  bus_a.spi_cs,  1'b1);
        checkOutput("abort spi_clk", bus_a.spi_clk, 1'b0);
        checkOutput("abort busy",    bus_a.busy,    1'b0);
        repeat (2) @(posedge clock);
        #1;
        checkOutput("abort err_count cleared",  bus_a.err_count,  8'h0);
        checkOutput("abort trigger_id cleared", bus_a.trigger_id, 16'h0);
        reset = 1'b0;
        repeat (1100) @(posedge clock);
        #1;
        checkOutput("no result after abort", res_pulses_a - res0, 0);
        applyStimulus(GOOD_B);
        waitResult(0, 1, 1100, cyc);
        checkOutput("post-abort latency", cyc,               1034);
        checkOutput("post-abort valid",   bus_a.frame_valid, 1'b1);
        checkOutput("post-abort id",      bus_a.trigger_id,  16'hA55A);

        $display("[TB] back-to-back at CLK_DIV=1");
        slave_frame = GOOD_A;
        pulses0     = clk_pulses_b;
        bus_b.start = 1'b1;
        @(posedge clock);
        #1;
        pat6 = '0;
        for (int i = 0; i < 6; i++) begin
            pat6 = {pat6[4:0], bus_b.spi_clk};
            if (i < 5) begin
                @(posedge clock);
                #1;
            end
        end
        checkOutput("div1 spi_clk waveform", pat6, 6'b001010);
        waitResult(1, 6, 300, cyc);
        checkOutput("div1 latency",        cyc,               260);
        checkOutput("div1 valid",          bus_b.frame_valid, 1'b1);
        checkOutput("div1 trigger_id",     bus_b.trigger_id,  16'h1234);
        checkOutput("div1 spi_clk pulses", clk_pulses_b - pulses0, 128);
        for (int k = 0; k < 2; k++) begin
            @(posedge clock);
            #1;
            waitResult(1, 1, 300, cyc);
            checkOutput("div1 back-to-back latency", cyc,               260);
            checkOutput("div1 back-to-back valid",   bus_b.frame_valid, 1'b1);
        end
        checkOutput("div1 err_count before bad run", bus_b.err_count, 8'd0);

        $display("[TB] 256 bad frames");
        slave_frame = BAD_START;
        for (int n = 1; n <= 256; n++) begin
            @(posedge clock);
            #1;
            waitResult(1, 1, 300, cyc);
            if (n == 1) begin
                checkOutput("div1 bad latency", cyc,               260);
                checkOutput("div1 bad error",   bus_b.frame_error, 1'b1);
            end
            if (n == 1 || n == 254 || n == 255 || n == 256) begin
                checkOutput("err_count saturation", bus_b.err_count,
                            (n < 255) ? 64'(n) : 64'd255);
            end
        end
        bus_b.start = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checkOutput("div1 idle after run",    bus_b.busy,      1'b0);
        checkOutput("err_count still 255",    bus_b.err_count, 8'd255);
        checkOutput("valid and error never together", both_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
